// File: rtl/altr_hps_en3_seq.sv
// altr_hps_en3_seq
//   Three-stage enable sequencer for the three inputs of altr_hps_nand3.
//   seq_req high raises en1 -> en2 -> en3 -> seq_done, each step separated by
//   max(dlyk,1) cycles; seq_req low drops them again in reverse order.
//
//   Handshake: seq_req is a level, not a pulse.  The FSM acts on a registered
//   copy of it, so the first output change appears one edge after seq_req is
//   captured.  There is no ready/ack; seq_busy and seq_done report progress.
//
//   Optional feature: define ALTR_HPS_EN3_SEQ_SYNC_EN to pass seq_req through
//   a 2-flop synchronizer first (every start latency grows by 2 cycles).
//
//   state_dbg exposes the FSM state register for observation.

module altr_hps_en3_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_req,
    input  logic [CNT_W-1:0] dly1,
    input  logic [CNT_W-1:0] dly2,
    input  logic [CNT_W-1:0] dly3,
    output logic             en1,
    output logic             en2,
    output logic             en3,
    output logic             seq_done,
    output logic             seq_busy,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        UP2  = 3'd2,
        UP3  = 3'd3,
        ON   = 3'd4,
        DN3  = 3'd5,
        DN2  = 3'd6,
        DN1  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             req_in;
    logic             en1_q, en1_d;
    logic             en2_q, en2_d;
    logic             en3_q, en3_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Counter load value for a stage: a programmed 0 behaves like 1.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dly);
        return (dly == '0) ? '0 : dly - CNT_W'(1);
    endfunction

`ifdef ALTR_HPS_EN3_SEQ_SYNC_EN
    logic req_s1_q, req_s2_q;

    // Two-flop synchronizer for an asynchronous seq_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
        end else begin
            req_s1_q <= seq_req;
            req_s2_q <= req_s1_q;
        end
    end

    assign req_in = req_s2_q;
`else
    assign req_in = seq_req;
`endif

    // Request capture: the FSM only ever sees a registered level.
    always_comb begin
        req_d = req_in;
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_q) begin
                    state_d = UP1;
                    cnt_d   = load_val(dly1);
                end
            end
            UP1: begin
                if (!req_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = UP2;
                    cnt_d   = load_val(dly2);
                end
            end
            UP2: begin
                // Abort keeps en1 up for the en1 spacing before dropping it.
                if (!req_q) begin
                    state_d = DN2;
                    cnt_d   = load_val(dly1);
                end else if (cnt_q == '0) begin
                    state_d = UP3;
                    cnt_d   = load_val(dly3);
                end
            end
            UP3: begin
                // Abort keeps en2 up for the en2 spacing before dropping it.
                if (!req_q) begin
                    state_d = DN3;
                    cnt_d   = load_val(dly2);
                end else if (cnt_q == '0) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                cnt_d = '0;
                if (!req_q) begin
                    state_d = DN3;
                    cnt_d   = load_val(dly3);
                end
            end
            // Down states ignore seq_req; a re-request is honoured from IDLE.
            DN3: begin
                if (cnt_q == '0) begin
                    state_d = DN2;
                    cnt_d   = load_val(dly2);
                end
            end
            DN2: begin
                if (cnt_q == '0) begin
                    state_d = DN1;
                    cnt_d   = load_val(dly1);
                end
            end
            DN1: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        en1_d  = (state_d != IDLE) && (state_d != DN1);
        en2_d  = (state_d == UP2) || (state_d == UP3) || (state_d == ON) || (state_d == DN3);
        en3_d  = (state_d == UP3) || (state_d == ON);
        done_d = (state_d == ON);
        busy_d = (state_d != IDLE) && (state_d != ON);
    end

    // State, counter and output registers; reset clears every enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            en3_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            en3_q   <= en3_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign en1       = en1_q;
    assign en2       = en2_q;
    assign en3       = en3_q;
    assign seq_done  = done_q;
    assign seq_busy  = busy_q;
    assign state_dbg = state_q;

endmodule
